// File: rtl/retire_trace_buffer.sv
// Retire trace buffer: compacts up to IssueWidth retired records per cycle into a
// circular FIFO with first-word-fall-through output and overflow/retire accounting.
module retire_trace_buffer #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned IssueWidth = 2,
    parameter int unsigned Depth      = 16,
    parameter int unsigned CntWidth   = 64,
    localparam int unsigned RecW      = 5 * XLEN + 6
) (
    input  logic                                 clk_i,
    input  logic                                 rstn_i,
    input  logic [IssueWidth-1:0]                in_valid_i,
    input  logic [IssueWidth-1:0][RecW-1:0]      in_rec_i,
    output logic                                 in_ready_o,
    input  logic                                 clear_i,
    output logic                                 out_valid_o,
    output logic [RecW-1:0]                      out_rec_o,
    input  logic                                 out_ready_i,
    output logic [CntWidth-1:0]                  retired_cnt_o,
    output logic [15:0]                          drop_cnt_o,
    output logic                                 overflow_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned OccW = $clog2(Depth) + 1;
    localparam int unsigned NW   = $clog2(IssueWidth + 1);

    logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [OccW-1:0]     count_q, count_d;
    logic [CntWidth-1:0] retired_q, retired_d;
    logic [15:0]         drop_q, drop_d;
    logic                ovf_q, ovf_d;

    logic [RecW-1:0]     mem_q [Depth];

    logic [NW-1:0]       n_valid;
    logic [NW-1:0]       n_acc;
    logic [PtrW-1:0]     slot_off [IssueWidth];
    logic [OccW-1:0]     free_slots;
    logic [16:0]         drop_sum;
    logic                accept;
    logic                pop;
    logic                wr_en;

    // Each valid slot lands at wr_ptr plus the number of valid slots below it.
    always_comb begin
        n_valid = '0;
        for (int i = 0; i < IssueWidth; i++) begin
            slot_off[i] = PtrW'(n_valid);
            n_valid     = n_valid + NW'(in_valid_i[i]);
        end
    end

    always_comb begin
        free_slots  = OccW'(Depth) - count_q;
        in_ready_o  = (free_slots >= OccW'(IssueWidth));
        accept      = in_ready_o;
        n_acc       = accept ? n_valid : '0;
        out_valid_o = (count_q != '0);
        pop         = out_valid_o && out_ready_i;
        out_rec_o   = out_valid_o ? mem_q[rd_ptr_q] : '0;
        wr_en       = accept && !clear_i;
    end

    always_comb begin
        wr_ptr_d  = wr_ptr_q + PtrW'(n_acc);
        rd_ptr_d  = rd_ptr_q + PtrW'(pop);
        count_d   = count_q + OccW'(n_acc) - OccW'(pop);
        retired_d = retired_q + CntWidth'(n_acc);
        ovf_d     = ovf_q;
        drop_d    = drop_q;
        drop_sum  = {1'b0, drop_q} + 17'(n_valid);
        if (!accept && (n_valid != '0)) begin
            ovf_d  = 1'b1;
            drop_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end
        // Clear wins over any push or pop, but the lifetime retire count survives.
        if (clear_i) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            count_d   = '0;
            retired_d = retired_q;
            ovf_d     = 1'b0;
            drop_d    = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            retired_q <= '0;
            drop_q    <= '0;
            ovf_q     <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            retired_q <= retired_d;
            drop_q    <= drop_d;
            ovf_q     <= ovf_d;
        end
    end

    // Storage is deliberately unreset; it is masked whenever the buffer is empty.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < IssueWidth; i++) begin
            if (wr_en && in_valid_i[i]) begin
                mem_q[wr_ptr_q + slot_off[i]] <= in_rec_i[i];
            end
        end
    end

    assign retired_cnt_o = retired_q;
    assign drop_cnt_o    = drop_q;
    assign overflow_o    = ovf_q;

endmodule

// File: tb/tb_retire_trace_buffer.sv
// Directed self-checking bench for retire_trace_buffer (IssueWidth=2, Depth=4).
module tb_retire_trace_buffer;

    localparam int unsigned XLEN = 32;
    localparam int unsigned IW   = 2;
    localparam int unsigned DEP  = 4;
    localparam int unsigned CW   = 64;
    localparam int unsigned RW   = 5 * XLEN + 6;

    logic                   clk_i;
    logic                   rstn_i;
    logic [IW-1:0]          in_valid_i;
    logic [IW-1:0][RW-1:0]  in_rec_i;
    logic                   in_ready_o;
    logic                   clear_i;
    logic                   out_valid_o;
    logic [RW-1:0]          out_rec_o;
    logic                   out_ready_i;
    logic [CW-1:0]          retired_cnt_o;
    logic [15:0]            drop_cnt_o;
    logic                   overflow_o;

    int n_checks = 0;
    int n_fail   = 0;

    retire_trace_buffer #(
        .XLEN      (XLEN),
        .IssueWidth(IW),
        .Depth     (DEP),
        .CntWidth  (CW)
    ) dut (
        .clk_i        (clk_i),
        .rstn_i       (rstn_i),
        .in_valid_i   (in_valid_i),
        .in_rec_i     (in_rec_i),
        .in_ready_o   (in_ready_o),
        .clear_i      (clear_i),
        .out_valid_o  (out_valid_o),
        .out_rec_o    (out_rec_o),
        .out_ready_i  (out_ready_i),
        .retired_cnt_o(retired_cnt_o),
        .drop_cnt_o   (drop_cnt_o),
        .overflow_o   (overflow_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    function automatic logic [RW-1:0] mkrec(input logic [31:0] pc);
        logic [RW-1:0] r;
        r = {pc, ~pc, pc[6:2], pc + 32'd1, pc ^ 32'h5a5a5a5a, pc + 32'd8, pc[2]};
        return r;
    endfunction

    function automatic logic [31:0] out_pc();
        return out_rec_o[RW-1 -: 32];
    endfunction

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push2(input logic [31:0] pc0, input logic [31:0] pc1);
        in_valid_i  = 2'b11;
        in_rec_i[0] = mkrec(pc0);
        in_rec_i[1] = mkrec(pc1);
        step();
        in_valid_i  = 2'b00;
    endtask

    task automatic push1(input logic [31:0] pc0);
        in_valid_i  = 2'b01;
        in_rec_i[0] = mkrec(pc0);
        in_rec_i[1] = '0;
        step();
        in_valid_i  = 2'b00;
    endtask

    task automatic test_reset();
        #3;
        n_checks++; if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got %b want 0", out_valid_o); end
        n_checks++; if (out_rec_o !== '0) begin n_fail++; $display("FAIL rst_out_rec got %h want 0", out_rec_o); end
        n_checks++; if (in_ready_o !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready got %b want 1", in_ready_o); end
        n_checks++; if (retired_cnt_o !== 64'd0) begin n_fail++; $display("FAIL rst_retired got %0d want 0", retired_cnt_o); end
        n_checks++; if (drop_cnt_o !== 16'd0 || overflow_o !== 1'b0) begin n_fail++; $display("FAIL rst_drop_ovf got %0d/%b want 0/0", drop_cnt_o, overflow_o); end
        #4 rstn_i = 1'b1;
        step();
    endtask

    task automatic test_dual_push();
        push2(32'h8000_0000, 32'h8000_0004);
        n_checks++; if (out_valid_o !== 1'b1) begin n_fail++; $display("FAIL dual_valid got %b want 1", out_valid_o); end
        n_checks++; if (out_rec_o !== mkrec(32'h8000_0000)) begin n_fail++; $display("FAIL dual_head got %h want %h", out_rec_o, mkrec(32'h8000_0000)); end
        n_checks++; if (retired_cnt_o !== 64'd2) begin n_fail++; $display("FAIL dual_retired got %0d want 2", retired_cnt_o); end
        n_checks++; if (in_ready_o !== 1'b1) begin n_fail++; $display("FAIL dual_ready got %b want 1", in_ready_o); end
        out_ready_i = 1'b1;
        step();
        n_checks++; if (out_pc() !== 32'h8000_0004) begin n_fail++; $display("FAIL dual_second got %h want 80000004", out_pc()); end
        step();
        out_ready_i = 1'b0;
        n_checks++; if (out_valid_o !== 1'b0 || out_rec_o !== '0) begin n_fail++; $display("FAIL dual_empty got %b/%h want 0/0", out_valid_o, out_rec_o); end
    endtask

    task automatic test_compaction();
        in_valid_i  = 2'b10;
        in_rec_i[0] = mkrec(32'hdead_beef);
        in_rec_i[1] = mkrec(32'h100);
        step();
        in_valid_i  = 2'b00;
        n_checks++; if (out_pc() !== 32'h100 || out_valid_o !== 1'b1) begin n_fail++; $display("FAIL cmp_head got %h/%b want 100/1", out_pc(), out_valid_o); end
        n_checks++; if (retired_cnt_o !== 64'd3) begin n_fail++; $display("FAIL cmp_retired got %0d want 3", retired_cnt_o); end
        push1(32'h104);
        out_ready_i = 1'b1;
        n_checks++; if (out_pc() !== 32'h100) begin n_fail++; $display("FAIL cmp_first got %h want 100", out_pc()); end
        step();
        n_checks++; if (out_pc() !== 32'h104) begin n_fail++; $display("FAIL cmp_adjacent got %h want 104", out_pc()); end
        step();
        out_ready_i = 1'b0;
        n_checks++; if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL cmp_empty got %b want 0", out_valid_o); end
    endtask

    task automatic test_overflow();
        push2(32'h200, 32'h204);
        push2(32'h208, 32'h20c);
        n_checks++; if (in_ready_o !== 1'b0) begin n_fail++; $display("FAIL ovf_full_ready got %b want 0", in_ready_o); end
        push2(32'h300, 32'h304);
        n_checks++; if (overflow_o !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got %b want 1", overflow_o); end
        n_checks++; if (drop_cnt_o !== 16'd2) begin n_fail++; $display("FAIL ovf_drop got %0d want 2", drop_cnt_o); end
        n_checks++; if (retired_cnt_o !== 64'd8) begin n_fail++; $display("FAIL ovf_retired got %0d want 8", retired_cnt_o); end
        n_checks++; if (out_pc() !== 32'h200) begin n_fail++; $display("FAIL ovf_head got %h want 200", out_pc()); end
        out_ready_i = 1'b1;
        step();
        out_ready_i = 1'b0;
        n_checks++; if (in_ready_o !== 1'b0) begin n_fail++; $display("FAIL ovf_after_pop_ready got %b want 0", in_ready_o); end
        out_ready_i = 1'b1;
        for (int k = 1; k < 4; k++) begin
            n_checks++; if (out_pc() !== 32'h200 + 32'(4 * k)) begin n_fail++; $display("FAIL ovf_drain%0d got %h want %h", k, out_pc(), 32'h200 + 32'(4 * k)); end
            step();
        end
        out_ready_i = 1'b0;
        n_checks++; if (overflow_o !== 1'b1 || out_valid_o !== 1'b0) begin n_fail++; $display("FAIL ovf_sticky got %b/%b want 1/0", overflow_o, out_valid_o); end
        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
        n_checks++; if (overflow_o !== 1'b0 || drop_cnt_o !== 16'd0 || retired_cnt_o !== 64'd8) begin
            n_fail++; $display("FAIL ovf_clear got ovf=%b drop=%0d ret=%0d want 0/0/8", overflow_o, drop_cnt_o, retired_cnt_o);
        end
    endtask

    task automatic test_concurrent();
        push2(32'h400, 32'h404);
        out_ready_i = 1'b1;
        push2(32'h408, 32'h40c);
        out_ready_i = 1'b0;
        n_checks++; if (in_ready_o !== 1'b0) begin n_fail++; $display("FAIL conc_ready got %b want 0 (count 3)", in_ready_o); end
        n_checks++; if (retired_cnt_o !== 64'd12) begin n_fail++; $display("FAIL conc_retired got %0d want 12", retired_cnt_o); end
        out_ready_i = 1'b1;
        for (int k = 1; k < 4; k++) begin
            n_checks++; if (out_pc() !== 32'h400 + 32'(4 * k)) begin n_fail++; $display("FAIL conc_order%0d got %h want %h", k, out_pc(), 32'h400 + 32'(4 * k)); end
            step();
        end
        out_ready_i = 1'b0;
        n_checks++; if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL conc_empty got %b want 0", out_valid_o); end
    endtask

    task automatic test_straddle();
        push2(32'h600, 32'h604);
        push1(32'h608);
        out_ready_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            n_checks++; if (out_pc() !== 32'h600 + 32'(4 * k)) begin n_fail++; $display("FAIL strd_pre%0d got %h want %h", k, out_pc(), 32'h600 + 32'(4 * k)); end
            step();
        end
        out_ready_i = 1'b0;
        push2(32'h610, 32'h614);
        n_checks++; if (out_pc() !== 32'h610) begin n_fail++; $display("FAIL strd_head got %h want 610", out_pc()); end
        out_ready_i = 1'b1;
        step();
        n_checks++; if (out_pc() !== 32'h614) begin n_fail++; $display("FAIL strd_wrapped got %h want 614", out_pc()); end
        step();
        out_ready_i = 1'b0;
        n_checks++; if (out_valid_o !== 1'b0 || retired_cnt_o !== 64'd17) begin n_fail++; $display("FAIL strd_end got %b/%0d want 0/17", out_valid_o, retired_cnt_o); end
    endtask

    task automatic test_wrap();
        out_ready_i = 1'b1;
        for (int k = 0; k <= 10; k++) begin
            in_valid_i  = (k < 10) ? 2'b01 : 2'b00;
            in_rec_i[0] = mkrec(32'(4 * k));
            if (k > 0) begin
                n_checks++; if (out_valid_o !== 1'b1 || out_pc() !== 32'(4 * (k - 1))) begin
                    n_fail++; $display("FAIL wrap%0d got %b/%h want 1/%h", k - 1, out_valid_o, out_pc(), 32'(4 * (k - 1)));
                end
            end
            step();
        end
        in_valid_i  = 2'b00;
        out_ready_i = 1'b0;
        n_checks++; if (out_valid_o !== 1'b0 || retired_cnt_o !== 64'd27) begin n_fail++; $display("FAIL wrap_end got %b/%0d want 0/27", out_valid_o, retired_cnt_o); end
    endtask

    task automatic test_reset_clear();
        push2(32'h700, 32'h704);
        push1(32'h708);
        #3 rstn_i = 1'b0;
        #1;
        n_checks++; if (out_valid_o !== 1'b0 || out_rec_o !== '0) begin n_fail++; $display("FAIL arst_out got %b/%h want 0/0", out_valid_o, out_rec_o); end
        n_checks++; if (retired_cnt_o !== 64'd0 || in_ready_o !== 1'b1) begin n_fail++; $display("FAIL arst_cnt got %0d/%b want 0/1", retired_cnt_o, in_ready_o); end
        #2 rstn_i = 1'b1;
        step();
        push2(32'h800, 32'h804);
        in_valid_i  = 2'b11;
        in_rec_i[0] = mkrec(32'h808);
        in_rec_i[1] = mkrec(32'h80c);
        clear_i     = 1'b1;
        out_ready_i = 1'b1;
        step();
        in_valid_i  = 2'b00;
        clear_i     = 1'b0;
        out_ready_i = 1'b0;
        n_checks++; if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin n_fail++; $display("FAIL clr_empty got %b/%b want 0/1", out_valid_o, in_ready_o); end
        n_checks++; if (retired_cnt_o !== 64'd2) begin n_fail++; $display("FAIL clr_retired got %0d want 2", retired_cnt_o); end
    endtask

    initial begin
        rstn_i      = 1'b0;
        in_valid_i  = '0;
        in_rec_i    = '0;
        clear_i     = 1'b0;
        out_ready_i = 1'b0;
        test_reset();
        test_dual_push();
        test_compaction();
        test_overflow();
        test_concurrent();
        test_straddle();
        test_wrap();
        test_reset_clear();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
